audioqsys_led_fader: RTL and testbench



---
 rtl/audioqsys_led_fader.sv | 84 ++++++++
 tb/tb_audioqsys_led_fader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audioqsys_led_fader.sv
// LED fader: turns each PIO on/off bit into a ramped brightness level and
// drives it onto its LED pin as free-running PWM.
module audioqsys_led_fader #(
  parameter int NUM_LEDS = 18,
  parameter int LVL_BITS = 8,
  parameter int TICK_DIV = 50000,
  parameter int STEP     = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic                fade_en,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [LVL_BITS-1:0] LMAX       = '1;
  localparam logic [LVL_BITS-1:0] PWM_LAST   = LMAX - 1'b1;
  localparam logic [LVL_BITS:0]   STEP_W     = (LVL_BITS+1)'(STEP);
  localparam logic [PW-1:0]       PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]                      presc;
  logic [LVL_BITS-1:0]                pwm_cnt;
  logic [NUM_LEDS-1:0][LVL_BITS-1:0]  lvl;
  logic [NUM_LEDS-1:0][LVL_BITS-1:0]  lvl_nxt;
  logic                               tick;

  assign tick = (presc == PRESC_LAST);

  // One extra bit catches overflow past LMAX and borrow below zero, so a
  // step that would overshoot clamps to the target instead of wrapping.
  function automatic logic [LVL_BITS-1:0] next_lvl(
    input logic [LVL_BITS-1:0] cur,
    input logic                on,
    input logic                en,
    input logic                tk
  );
    logic [LVL_BITS:0]   wide;
    logic [LVL_BITS-1:0] res;
    res  = cur;
    wide = '0;
    if (!en) begin
      res = on ? LMAX : '0;
    end else if (tk) begin
      if (on) begin
        wide = {1'b0, cur} + STEP_W;
        res  = (wide >= {1'b0, LMAX}) ? LMAX : wide[LVL_BITS-1:0];
      end else begin
        wide = {1'b0, cur} - STEP_W;
        res  = wide[LVL_BITS] ? '0 : wide[LVL_BITS-1:0];
      end
    end
    return res;
  endfunction

  always_comb begin
    lvl_nxt = lvl;
    busy    = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      lvl_nxt[i] = next_lvl(lvl[i], led_in[i], fade_en, tick);
      if (lvl[i] != (led_in[i] ? LMAX : '0)) busy = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
      lvl     <= '0;
      led_out <= '0;
    end else begin
      presc   <= tick ? '0 : presc + 1'b1;
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      lvl     <= lvl_nxt;
      // Compare uses the current level, so a level change shows on the pin
      // one cycle after it lands in lvl.
      for (int i = 0; i < NUM_LEDS; i++) begin
        led_out[i] <= (lvl[i] > pwm_cnt);
      end
    end
  end

endmodule

// File: tb/tb_audioqsys_led_fader.sv
// Directed bench for audioqsys_led_fader: reset, ramp, duty, reversal,
// snap and reset-mid-fade scenarios with hand-computed expectations.
module tb_audioqsys_led_fader;

  localparam int N = 18;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] led_in, led_out;
  logic         fade_en, busy;
  logic [N-1:0] led_in_d, led_out_d;
  logic         fade_en_d, busy_d;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  audioqsys_led_fader #(.NUM_LEDS(N), .LVL_BITS(8), .TICK_DIV(4), .STEP(64)) dut (
    .clk(clk), .reset_n(reset_n), .led_in(led_in), .fade_en(fade_en),
    .led_out(led_out), .busy(busy)
  );

  // Slow-tick instance: a level reached by one tick is held long enough to
  // measure a full PWM period.
  audioqsys_led_fader #(.NUM_LEDS(N), .LVL_BITS(8), .TICK_DIV(1000), .STEP(128)) dut_d (
    .clk(clk), .reset_n(reset_n), .led_in(led_in_d), .fade_en(fade_en_d),
    .led_out(led_out_d), .busy(busy_d)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_change(input logic [7:0] prev, output int n);
    n = 0;
    while (dut.lvl[0] == prev && n < 16) begin
      step();
      n++;
    end
  endtask

  task automatic wait_lvl(input logic [7:0] target);
    int n;
    n = 0;
    while (dut.lvl[0] != target && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic clear_levels();
    fade_en = 1'b0;
    led_in  = '0;
    step();
  endtask

  task automatic test_reset();
    int bad;
    reset_n = 1'b0;
    led_in  = '1;
    fade_en = 1'b0;
    step(3);
    checks++;
    if (led_out !== '0) begin
      failures++; $display("FAIL reset_led_out got=%h exp=%h", led_out, 18'h0);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL reset_busy got=%b exp=1", busy);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (led_out !== '0) begin
      failures++; $display("FAIL edge1_led_out got=%h exp=%h", led_out, 18'h0);
    end
    checks++;
    if (dut.lvl[5] !== 8'd255 || busy !== 1'b0) begin
      failures++; $display("FAIL edge1_lvl got=%0d busy=%b exp=255 busy=0", dut.lvl[5], busy);
    end
    step();
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (led_out !== '1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL full_on_constant bad_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_ramp_up();
    logic [7:0] prev;
    int n;
    bit first;
    clear_levels();
    fade_en = 1'b1;
    led_in  = 18'h00001;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL ramp_busy_start got=%b exp=1", busy);
    end
    exp_q = '{8'd64, 8'd128, 8'd192, 8'd255};
    prev  = 8'd0;
    first = 1'b1;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      wait_change(prev, n);
      checks++;
      if (dut.lvl[0] !== e) begin
        failures++; $display("FAIL ramp_lvl got=%0d exp=%0d", dut.lvl[0], e);
      end
      checks++;
      if (first ? (n < 1 || n > 4) : (n != 4)) begin
        failures++; $display("FAIL ramp_spacing got=%0d exp=%s", n, first ? "1..4" : "4");
      end
      checks++;
      if (busy !== (e != 8'd255)) begin
        failures++; $display("FAIL ramp_busy got=%b exp=%b", busy, e != 8'd255);
      end
      checks++;
      if (dut.lvl[N-1:1] !== '0) begin
        failures++; $display("FAIL ramp_others got=%h exp=0", dut.lvl[N-1:1]);
      end
      prev  = e;
      first = 1'b0;
    end
    step(12);
    checks++;
    if (dut.lvl[0] !== 8'd255 || busy !== 1'b0) begin
      failures++; $display("FAIL ramp_hold got=%0d busy=%b exp=255 busy=0", dut.lvl[0], busy);
    end
  endtask

  task automatic test_duty();
    int hi;
    int n;
    fade_en = 1'b0;
    led_in  = 18'h00001;
    step(2);
    hi = 0;
    for (int i = 0; i < 255; i++) begin
      if (led_out[0]) hi++;
      step();
    end
    checks++;
    if (hi != 255) begin
      failures++; $display("FAIL duty_full got=%0d exp=255", hi);
    end
    led_in = '0;
    step(2);
    hi = 0;
    for (int i = 0; i < 255; i++) begin
      if (led_out[0]) hi++;
      step();
    end
    checks++;
    if (hi != 0) begin
      failures++; $display("FAIL duty_zero got=%0d exp=0", hi);
    end
    led_in_d = 18'h00001;
    n = 0;
    while (dut_d.lvl[0] == 8'd0 && n < 1100) begin
      step();
      n++;
    end
    checks++;
    if (dut_d.lvl[0] !== 8'd128) begin
      failures++; $display("FAIL duty_mid_lvl got=%0d exp=128", dut_d.lvl[0]);
    end
    step(2);
    hi = 0;
    for (int i = 0; i < 255; i++) begin
      if (led_out_d[0]) hi++;
      step();
    end
    checks++;
    if (hi != 128) begin
      failures++; $display("FAIL duty_mid got=%0d exp=128", hi);
    end
  endtask

  task automatic test_reversal();
    logic [7:0] prev;
    int n;
    clear_levels();
    fade_en = 1'b1;
    led_in  = 18'h00001;
    wait_lvl(8'd128);
    led_in = '0;
    #1;
    checks++;
    if (dut.lvl[0] !== 8'd128 || busy !== 1'b1) begin
      failures++; $display("FAIL rev_start got=%0d busy=%b exp=128 busy=1", dut.lvl[0], busy);
    end
    exp_q = '{8'd64, 8'd0};
    prev  = 8'd128;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      wait_change(prev, n);
      checks++;
      if (dut.lvl[0] !== e) begin
        failures++; $display("FAIL rev_lvl got=%0d exp=%0d", dut.lvl[0], e);
      end
      prev = e;
    end
    step(12);
    checks++;
    if (dut.lvl[0] !== 8'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL rev_floor got=%0d busy=%b exp=0 busy=0", dut.lvl[0], busy);
    end
  endtask

  task automatic test_snap();
    clear_levels();
    fade_en = 1'b1;
    led_in  = 18'h00001;
    wait_lvl(8'd64);
    checks++;
    if (dut.lvl[0] !== 8'd64 || busy !== 1'b1) begin
      failures++; $display("FAIL snap_pre got=%0d busy=%b exp=64 busy=1", dut.lvl[0], busy);
    end
    fade_en = 1'b0;
    step();
    checks++;
    if (dut.lvl[0] !== 8'd255 || busy !== 1'b0) begin
      failures++; $display("FAIL snap_lvl got=%0d busy=%b exp=255 busy=0", dut.lvl[0], busy);
    end
  endtask

  task automatic test_reset_mid_fade();
    int n;
    clear_levels();
    fade_en = 1'b1;
    led_in  = 18'h00001;
    wait_lvl(8'd192);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (dut.lvl[0] !== 8'd0 || led_out !== '0) begin
      failures++; $display("FAIL rst_mid got lvl=%0d led_out=%h exp lvl=0 led_out=0", dut.lvl[0], led_out);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL rst_mid_busy got=%b exp=1", busy);
    end
    step();
    reset_n = 1'b1;
    wait_change(8'd0, n);
    checks++;
    if (dut.lvl[0] !== 8'd64 || n != 4) begin
      failures++; $display("FAIL rst_restart got lvl=%0d cycles=%0d exp lvl=64 cycles=4", dut.lvl[0], n);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    led_in    = '0;
    fade_en   = 1'b0;
    led_in_d  = '0;
    fade_en_d = 1'b1;
    test_reset();
    test_ramp_up();
    test_duty();
    test_reversal();
    test_snap();
    test_reset_mid_fade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
